// File: rtl/rns_alu_mc_seq.sv
// rns_alu_mc_seq: NUM_CH-channel RNS ALU (add/sub/mul/MAC) with one operation in flight.
// Latency: add/sub out_valid at T+2 after accept at T; mul/MAC at T+2+2W.
// Backpressure: in_ready only in IDLE; dout/err held in DONE until out_ready.
// Optional macro RNS_RANGE_CHK_EN: builds operand range comparators that drive err.
module rns_alu_mc_seq #(
  parameter int NUM_CH = 2,
  parameter int W      = 8,
  parameter logic [NUM_CH*(W+1)-1:0] MODULI = {9'd129, 9'd256}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          op,
  input  logic                acc_clr,
  input  logic [NUM_CH*W-1:0] op1_in,
  input  logic [NUM_CH*W-1:0] op2_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUM_CH*W-1:0] dout,
  output logic                err
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MAC = 2'b11;

  // Reduction step counter: one raw product bit per cycle, 2W cycles in total.
  localparam int                CNT_W    = $clog2(2 * W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(2 * W - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_REDUCE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_finish;
  logic [1:0]       r_op;
  logic             r_acc_clr;
  logic [CNT_W-1:0] r_cnt;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake decode; w_finish marks the cycle whose result enters DONE.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        // op[1] selects the multiply family, which needs the serial reducer.
        if (r_op[1]) begin
          w_state_nxt = S_REDUCE;
        end else begin
          w_state_nxt = S_DONE;
          w_finish    = 1'b1;
        end
      end
      S_REDUCE: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_DONE;
          w_finish    = 1'b1;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Capture opcode/acc_clr at accept and step the reduction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op      <= OP_ADD;
      r_acc_clr <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (w_accept) begin
        r_op      <= op;
        r_acc_clr <= acc_clr;
      end
      if (r_state == S_CALC) begin
        r_cnt <= '0;
      end else if (r_state == S_REDUCE) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

`ifdef RNS_RANGE_CHK_EN
  logic [NUM_CH-1:0] w_rng_bad;
`endif

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    localparam logic [W:0] LP_M = MODULI[gi*(W+1) +: (W+1)];

    logic [W-1:0]   r_op1;
    logic [W-1:0]   r_op2;
    logic [W-1:0]   r_acc;
    logic [W-1:0]   r_dout;
    logic [2*W-1:0] r_raw;
    logic [W:0]     r_rem;

    logic [W:0]     w_sum;
    logic [W:0]     w_sum_sub;
    logic [W+1:0]   w_dif;
    logic [W+1:0]   w_dif_sub;
    logic [W-1:0]   w_addsub;
    logic [W-1:0]   w_acc_eff;
    logic [2*W-1:0] w_prod;
    logic [W+1:0]   w_shift;
    logic [W+1:0]   w_shift_sub;
    logic [W:0]     w_rem_nxt;
    logic [W-1:0]   w_result;

    // Per-channel datapath: single conditional subtract for add/sub, raw product for mul/MAC,
    // and one shift-subtract reduction step.
    always_comb begin
      w_sum     = {1'b0, r_op1} + {1'b0, r_op2};
      w_sum_sub = w_sum - LP_M;
      // op1 + m - op2 stays non-negative for in-range operands and is below 2m.
      w_dif     = {2'b00, r_op1} + {1'b0, LP_M} - {2'b00, r_op2};
      w_dif_sub = w_dif - {1'b0, LP_M};
      w_addsub  = '0;
      if (r_op == OP_SUB) begin
        w_addsub = (w_dif >= {1'b0, LP_M}) ? w_dif_sub[W-1:0] : w_dif[W-1:0];
      end else begin
        w_addsub = (w_sum >= LP_M) ? w_sum_sub[W-1:0] : w_sum[W-1:0];
      end

      w_acc_eff = '0;
      if ((r_op == OP_MAC) && !r_acc_clr) begin
        w_acc_eff = r_acc;
      end
      w_prod = ({{W{1'b0}}, r_op1} * {{W{1'b0}}, r_op2}) + {{W{1'b0}}, w_acc_eff};

      w_shift     = {r_rem, r_raw[2*W-1]};
      w_shift_sub = w_shift - {1'b0, LP_M};
      w_rem_nxt   = (w_shift >= {1'b0, LP_M}) ? w_shift_sub[W:0] : w_shift[W:0];

      w_result = (r_state == S_REDUCE) ? w_rem_nxt[W-1:0] : w_addsub;
    end

    // Operand capture, serial reduction, and result/accumulator update on entering DONE.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_op1  <= '0;
        r_op2  <= '0;
        r_acc  <= '0;
        r_dout <= '0;
        r_raw  <= '0;
        r_rem  <= '0;
      end else begin
        if (w_accept) begin
          r_op1 <= op1_in[gi*W +: W];
          r_op2 <= op2_in[gi*W +: W];
        end
        if (r_state == S_CALC) begin
          r_raw <= w_prod;
          r_rem <= '0;
        end else if (r_state == S_REDUCE) begin
          r_raw <= {r_raw[2*W-2:0], 1'b0};
          r_rem <= w_rem_nxt;
        end
        if (w_finish) begin
          r_dout <= w_result;
          if (r_op == OP_MAC) begin
            r_acc <= w_result;
          end else if (r_acc_clr) begin
            r_acc <= '0;
          end
        end
      end
    end

    assign dout[gi*W +: W] = r_dout;

`ifdef RNS_RANGE_CHK_EN
    assign w_rng_bad[gi] = ({1'b0, op1_in[gi*W +: W]} >= LP_M) |
                           ({1'b0, op2_in[gi*W +: W]} >= LP_M);
`endif
  end

`ifdef RNS_RANGE_CHK_EN
  logic r_err_pend;
  logic r_err;

  // Range flag sampled at accept, presented together with the result in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_pend <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_err_pend <= |w_rng_bad;
      end
      if (w_finish) begin
        r_err <= r_err_pend;
      end else if ((r_state == S_DONE) && out_ready) begin
        r_err <= 1'b0;
      end
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rns_alu_mc_seq.sv
// Self-checking bench for rns_alu_mc_seq: directed cases plus randomized ops
// compared against a modular-arithmetic reference model.
module tb_rns_alu_mc_seq;

  localparam int NUM_CH = 2;
  localparam int W      = 8;
  localparam int DW     = NUM_CH * W;
  localparam logic [NUM_CH*(W+1)-1:0] MODULI = {9'd129, 9'd256};
  localparam int LAT_AS = 2;
  localparam int LAT_MM = 2 + 2 * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    op;
  logic          acc_clr;
  logic [DW-1:0] op1_in;
  logic [DW-1:0] op2_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] dout;
  logic          err;

  int n_pass  = 0;
  int n_total = 0;

  int unsigned mod_m   [NUM_CH];
  int unsigned ref_acc [NUM_CH];

  rns_alu_mc_seq #(.NUM_CH(NUM_CH), .W(W), .MODULI(MODULI)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .acc_clr(acc_clr), .op1_in(op1_in), .op2_in(op2_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .err(err)
  );

  always #5 clk = ~clk;

  // Reference: plain modular arithmetic per channel plus accumulator bookkeeping.
  task automatic model_op(input logic [1:0] o, input logic c,
                          input logic [DW-1:0] a, input logic [DW-1:0] b,
                          output logic [DW-1:0] d, output logic e);
    int unsigned av, bv, m, acc, r;
    d = '0;
    e = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      av  = a[ch*W +: W];
      bv  = b[ch*W +: W];
      m   = mod_m[ch];
      acc = c ? 0 : ref_acc[ch];
      case (o)
        2'd0:    r = (av + bv) % m;
        2'd1:    r = (av + m - bv) % m;
        2'd2:    r = (av * bv) % m;
        default: r = (av * bv + acc) % m;
      endcase
      d[ch*W +: W] = W'(r);
      if (o == 2'd3)  ref_acc[ch] = r;
      else if (c)     ref_acc[ch] = 0;
      if (av >= m || bv >= m) e = 1'b1;
    end
`ifndef RNS_RANGE_CHK_EN
    e = 1'b0;
`endif
  endtask

  // Issue one operation, wait (bounded) for the result, then consume it.
  task automatic run_op(input logic [1:0] o, input logic c,
                        input logic [DW-1:0] a, input logic [DW-1:0] b,
                        output logic [DW-1:0] d, output logic e, output int lat);
    int k;
    lat = -1;
    d   = '0;
    e   = 1'b0;
    k   = 0;
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    in_valid = 1'b1; op = o; acc_clr = c; op1_in = a; op2_in = b;
    @(posedge clk);
    @(negedge clk);
    // Scramble inputs: they only need to be stable in the accept cycle.
    in_valid = 1'b0;
    op       = 2'($urandom);
    acc_clr  = 1'($urandom);
    op1_in   = DW'($urandom);
    op2_in   = DW'($urandom);
    k = 1;
    while (!out_valid && k < 100) begin @(negedge clk); k++; end
    if (out_valid) begin
      lat = k;
      d   = dout;
      e   = err;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; op = '0; acc_clr = 1'b0;
    op1_in = '0; op2_in = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else n_pass++;
    n_total++; if (dout !== '0) $display("FAIL reset_dout got=%h exp=0", dout); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else n_pass++;
    for (int ch = 0; ch < NUM_CH; ch++) ref_acc[ch] = 0;
  endtask

  task automatic test_add();
    logic [DW-1:0] d, ed; logic e, ee; int lat;
    model_op(2'd0, 1'b0, {8'd100, 8'd200}, {8'd100, 8'd100}, ed, ee);
    run_op(2'd0, 1'b0, {8'd100, 8'd200}, {8'd100, 8'd100}, d, e, lat);
    n_total++; if (lat !== LAT_AS) $display("FAIL add_latency got=%0d exp=%0d", lat, LAT_AS); else n_pass++;
    n_total++; if (d !== {8'd71, 8'd44}) $display("FAIL add_dout got=%h exp=%h", d, {8'd71, 8'd44}); else n_pass++;
    n_total++; if (d !== ed) $display("FAIL add_model got=%h exp=%h", d, ed); else n_pass++;
  endtask

  task automatic test_sub();
    logic [DW-1:0] d, ed; logic e, ee; int lat;
    model_op(2'd1, 1'b0, {8'd5, 8'd5}, {8'd10, 8'd10}, ed, ee);
    run_op(2'd1, 1'b0, {8'd5, 8'd5}, {8'd10, 8'd10}, d, e, lat);
    n_total++; if (lat !== LAT_AS) $display("FAIL sub_latency got=%0d exp=%0d", lat, LAT_AS); else n_pass++;
    n_total++; if (d !== {8'd124, 8'd251}) $display("FAIL sub_dout got=%h exp=%h", d, {8'd124, 8'd251}); else n_pass++;
    n_total++; if (d !== ed) $display("FAIL sub_model got=%h exp=%h", d, ed); else n_pass++;
  endtask

  task automatic test_mul();
    logic [DW-1:0] d, ed; logic e, ee; int lat;
    model_op(2'd2, 1'b0, {8'd128, 8'd200}, {8'd128, 8'd200}, ed, ee);
    run_op(2'd2, 1'b0, {8'd128, 8'd200}, {8'd128, 8'd200}, d, e, lat);
    n_total++; if (lat !== LAT_MM) $display("FAIL mul_latency got=%0d exp=%0d", lat, LAT_MM); else n_pass++;
    n_total++; if (d !== {8'd1, 8'd64}) $display("FAIL mul_dout got=%h exp=%h", d, {8'd1, 8'd64}); else n_pass++;
    n_total++; if (d !== ed) $display("FAIL mul_model got=%h exp=%h", d, ed); else n_pass++;
  endtask

  task automatic test_mac();
    logic [DW-1:0] d, ed; logic e, ee; int lat;
    model_op(2'd3, 1'b1, {8'd3, 8'd3}, {8'd4, 8'd4}, ed, ee);
    run_op(2'd3, 1'b1, {8'd3, 8'd3}, {8'd4, 8'd4}, d, e, lat);
    n_total++; if (lat !== LAT_MM) $display("FAIL mac1_latency got=%0d exp=%0d", lat, LAT_MM); else n_pass++;
    n_total++; if (d !== {8'd12, 8'd12}) $display("FAIL mac1_dout got=%h exp=%h", d, {8'd12, 8'd12}); else n_pass++;
    model_op(2'd3, 1'b0, {8'd13, 8'd10}, {8'd10, 8'd13}, ed, ee);
    run_op(2'd3, 1'b0, {8'd13, 8'd10}, {8'd10, 8'd13}, d, e, lat);
    n_total++; if (d !== {8'd13, 8'd142}) $display("FAIL mac2_dout got=%h exp=%h", d, {8'd13, 8'd142}); else n_pass++;
    n_total++; if (d !== ed) $display("FAIL mac2_model got=%h exp=%h", d, ed); else n_pass++;
    model_op(2'd0, 1'b1, {8'd20, 8'd30}, {8'd40, 8'd50}, ed, ee);
    run_op(2'd0, 1'b1, {8'd20, 8'd30}, {8'd40, 8'd50}, d, e, lat);
    n_total++; if (d !== ed) $display("FAIL mac3_add_dout got=%h exp=%h", d, ed); else n_pass++;
    model_op(2'd3, 1'b0, {8'd1, 8'd1}, {8'd1, 8'd1}, ed, ee);
    run_op(2'd3, 1'b0, {8'd1, 8'd1}, {8'd1, 8'd1}, d, e, lat);
    n_total++; if (d !== {8'd1, 8'd1}) $display("FAIL mac3_dout got=%h exp=%h", d, {8'd1, 8'd1}); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] ed; logic ee; int k;
    model_op(2'd0, 1'b0, {8'd7, 8'd9}, {8'd1, 8'd2}, ed, ee);
    in_valid = 1'b1; op = 2'd0; acc_clr = 1'b0; op1_in = {8'd7, 8'd9}; op2_in = {8'd1, 8'd2};
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 100) begin @(negedge clk); k++; end
    n_total++; if (out_valid !== 1'b1) $display("FAIL bp_first_valid got=%b exp=1", out_valid); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        in_valid = 1'b1; op = 2'd2; acc_clr = 1'b1; op1_in = {8'd99, 8'd99}; op2_in = {8'd3, 8'd3};
      end
      if (i == 3) in_valid = 1'b0;
      @(negedge clk);
      n_total++; if (out_valid !== 1'b1) $display("FAIL bp_hold_valid cyc=%0d got=%b exp=1", i, out_valid); else n_pass++;
      n_total++; if (dout !== ed) $display("FAIL bp_hold_dout cyc=%0d got=%h exp=%h", i, dout, ed); else n_pass++;
      n_total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); else n_pass++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_total++; if (in_ready !== 1'b1) $display("FAIL bp_ready_after_hs got=%b exp=1", in_ready); else n_pass++;
    k = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid) k++;
    end
    n_total++; if (k !== 0) $display("FAIL bp_no_stray_op got=%0d valid cycles exp=0", k); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d, ed; logic e, ee; int lat, k;
    model_op(2'd3, 1'b1, {8'd50, 8'd60}, {8'd70, 8'd80}, ed, ee);
    run_op(2'd3, 1'b1, {8'd50, 8'd60}, {8'd70, 8'd80}, d, e, lat);
    n_total++; if (d !== ed) $display("FAIL rm_setup_dout got=%h exp=%h", d, ed); else n_pass++;
    in_valid = 1'b1; op = 2'd2; acc_clr = 1'b0; op1_in = {8'd33, 8'd44}; op2_in = {8'd55, 8'd66};
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) ref_acc[ch] = 0;
    n_total++; if (out_valid !== 1'b0) $display("FAIL rm_out_valid got=%b exp=0", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL rm_in_ready got=%b exp=1", in_ready); else n_pass++;
    n_total++; if (dout !== '0) $display("FAIL rm_dout got=%h exp=0", dout); else n_pass++;
    k = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid) k++;
    end
    n_total++; if (k !== 0) $display("FAIL rm_abandoned got=%0d valid cycles exp=0", k); else n_pass++;
    model_op(2'd3, 1'b0, {8'd7, 8'd9}, {8'd5, 8'd3}, ed, ee);
    run_op(2'd3, 1'b0, {8'd7, 8'd9}, {8'd5, 8'd3}, d, e, lat);
    n_total++; if (d !== {8'd35, 8'd27}) $display("FAIL rm_acc_cleared got=%h exp=%h", d, {8'd35, 8'd27}); else n_pass++;
  endtask

  task automatic test_range();
    logic [DW-1:0] d, ed; logic e, ee; int lat;
    model_op(2'd0, 1'b0, {8'd200, 8'd10}, {8'd1, 8'd1}, ed, ee);
    run_op(2'd0, 1'b0, {8'd200, 8'd10}, {8'd1, 8'd1}, d, e, lat);
    n_total++; if (lat !== LAT_AS) $display("FAIL rng_latency got=%0d exp=%0d", lat, LAT_AS); else n_pass++;
    n_total++; if (e !== ee) $display("FAIL rng_err_out got=%b exp=%b", e, ee); else n_pass++;
    model_op(2'd0, 1'b0, {8'd128, 8'd255}, {8'd0, 8'd0}, ed, ee);
    run_op(2'd0, 1'b0, {8'd128, 8'd255}, {8'd0, 8'd0}, d, e, lat);
    n_total++; if (e !== 1'b0) $display("FAIL rng_err_edge got=%b exp=0", e); else n_pass++;
    n_total++; if (d !== ed) $display("FAIL rng_edge_dout got=%h exp=%h", d, ed); else n_pass++;
    model_op(2'd2, 1'b0, {8'd250, 8'd3}, {8'd251, 8'd5}, ed, ee);
    run_op(2'd2, 1'b0, {8'd250, 8'd3}, {8'd251, 8'd5}, d, e, lat);
    n_total++; if (e !== ee) $display("FAIL rng_mul_err got=%b exp=%b", e, ee); else n_pass++;
    n_total++; if (d !== ed) $display("FAIL rng_mul_dout got=%h exp=%h", d, ed); else n_pass++;
  endtask

  task automatic test_random();
    logic [DW-1:0] a, b, d, ed; logic e, ee, c; logic [1:0] o; int lat, el;
    for (int it = 0; it < 40; it++) begin
      o = 2'($urandom_range(0, 3));
      c = ($urandom_range(0, 3) == 0);
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (o[1]) begin
          a[ch*W +: W] = W'($urandom_range(0, 255));
          b[ch*W +: W] = W'($urandom_range(0, 255));
        end else begin
          a[ch*W +: W] = W'($urandom_range(0, mod_m[ch] - 1));
          b[ch*W +: W] = W'($urandom_range(0, mod_m[ch] - 1));
        end
      end
      el = o[1] ? LAT_MM : LAT_AS;
      model_op(o, c, a, b, ed, ee);
      run_op(o, c, a, b, d, e, lat);
      n_total++; if (d !== ed) $display("FAIL rand_dout it=%0d op=%0d clr=%b a=%h b=%h got=%h exp=%h", it, o, c, a, b, d, ed); else n_pass++;
      n_total++; if (e !== ee) $display("FAIL rand_err it=%0d got=%b exp=%b", it, e, ee); else n_pass++;
      n_total++; if (lat !== el) $display("FAIL rand_latency it=%0d got=%0d exp=%0d", it, lat, el); else n_pass++;
    end
  endtask

  initial begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      mod_m[ch]   = MODULI[ch*(W+1) +: (W+1)];
      ref_acc[ch] = 0;
    end
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_mac();
    test_backpressure();
    test_reset_mid();
    test_range();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rns_alu_mc_seq.md
Name: rns_alu_mc_seq

Overview:
Multi-channel, multi-cycle RNS ALU for the EX stage. It processes NUM_CH residue channels in lockstep, one modulus per channel, each fixed by parameter. It supports add, sub, mul and multiply-accumulate (MAC). Every operation reduces exactly into [0, m-1] through an iterative shift-subtract reducer, so the modulus is not limited to a hard-coded value. The block uses valid/ready handshakes on input and output and holds one operation in flight at a time.

Parameters:
NUM_CH, 2, number of residue channels.
W, 8, residue width per channel in bits.
MODULI, {9'd129, 9'd256}, packed moduli, (W+1) bits each. Channel i modulus = MODULI[i*(W+1) +: W+1]; channel 0 is in the LSBs. Each modulus must satisfy 2 <= m <= 2^W.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  operation request.
in_ready  output  1  high only in IDLE.
op  input  2  00 add, 01 sub, 10 mul, 11 MAC.
acc_clr  input  1  sampled on accept; treats all channel accumulators as 0 for this operation.
op1_in  input  NUM_CH*W  operand 1; channel i at [i*W +: W].
op2_in  input  NUM_CH*W  operand 2, same packing.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts the result.
dout  output  NUM_CH*W  residues, same packing.
err  output  1  range-check flag; see Optional Feature.

Behaviour:
- Reset, synchronous: state=IDLE, out_valid=0, dout=0, err=0, all accumulators=0, in_ready=1 from the first cycle after reset.
- A reset mid-operation (CALC, REDUCE or DONE) abandons the operation with no output.
- Accept happens when in_valid & in_ready (cycle T). At accept the block registers op, operands and acc_clr, and moves to CALC.
- States: IDLE -> CALC -> (REDUCE | DONE) -> DONE -> IDLE.
- CALC (T+1), add: s = op1+op2 in W+1 bits; result = s>=m ? s-m : s. Then go to DONE.
- CALC, sub: s = op1 - op2 + m in W+2 bits; same conditional subtract. Then go to DONE.
- Add/sub assume in-range operands; the result for out-of-range operands is unspecified.
- CALC, mul: raw = op1*op2 in 2W bits. Then go to REDUCE.
- CALC, MAC: raw = op1*op2 + acc_i in 2W bits, where acc_i is taken as 0 if acc_clr was sampled. The value cannot overflow because (2^W-1)^2 + 2^W - 1 < 2^(2W). Then go to REDUCE.
- REDUCE: exactly 2W cycles, one raw bit per cycle, MSB first. Per cycle: rem = {rem, bit}; if rem >= m then rem -= m. rem is W+1 bits and clears to 0 on entering REDUCE.
- Mul/MAC results are exact for any operand values.
- DONE: out_valid=1. dout and err hold stable until out_ready; no glitches.
- Latency: add/sub out_valid rises at T+2; mul/MAC at T+2+2W (T+18 at the default W).
- A handshake in DONE (out_valid & out_ready) moves to IDLE; in_ready rises the next cycle.
- Throughput: at most one operation per (latency+1) cycles.
- Accumulator, on entering DONE:
  - MAC: acc_i := result_i.
  - Any other op accepted with acc_clr=1: acc := 0.
  - Otherwise acc is unchanged.
- in_valid outside IDLE is ignored (not queued). op and operands need only be stable in the accept cycle.
- out_ready outside DONE is ignored.
- All channels share one FSM and finish in the same cycle.

Optional Feature:
Macro RNS_RANGE_CHK_EN.
- Defined: at accept, err_next = OR over channels of (op1_i >= m_i) | (op2_i >= m_i). err is registered and presented with out_valid. dout is computed as normal.
- Undefined: err is tied to 0 and no comparators are built.

Test Plan:
Add: op1={ch1 100, ch0 200}, op2={100, 100}, op=00 -> at T+2, dout ch0=44, ch1=71.
Sub: op1={5,5}, op2={10,10}, op=01 -> at T+2, ch0=251, ch1=124.
Mul: op1={128,200}, op2={128,200}, op=10 -> out_valid at T+18; ch0=64, ch1=1.
MAC sequence:
- op=11, acc_clr=1, op1={3,3}, op2={4,4} -> both channels 12.
- Then op=11, acc_clr=0, op1={13,10}, op2={10,13} -> ch0=142, ch1=13.
- Then op=00 with acc_clr=1, followed by MAC {1,1}*{1,1} -> both channels 1.
Backpressure and reset:
- Hold out_ready=0 for 5 cycles in DONE and pulse in_valid -> dout and out_valid stable, in_ready=0, no new accept.
- Assert rst at T+8 of a mul -> next cycle out_valid=0, in_ready=1, accumulators 0.
Range check (macro defined): add op1 ch1=200 (m=129) -> err=1 with out_valid. Same stimulus with the macro undefined -> err=0.
